// File: rtl/tick_mon_pkg.sv
// Shared definitions for the tick period monitor.
//   state_t    : FSM encoding (IDLE waits for a first tick, MEAS times intervals)
//   lo_bound   : lowest in-tolerance interval (NOM_PERIOD - TOL)
//   hi_bound   : highest in-tolerance interval, also the timeout point
//   min_cnt_w  : smallest counter width able to hold hi_bound
package tick_mon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  function automatic int lo_bound(input int nom, input int tol);
    return nom - tol;
  endfunction

  function automatic int hi_bound(input int nom, input int tol);
    return nom + tol;
  endfunction

  function automatic int min_cnt_w(input int nom, input int tol);
    return $clog2(hi_bound(nom, tol) + 1);
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the tick input.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_tick  : tick level, synchronous to clk
//   o_rise  : combinational pulse, high in the first cycle i_tick is high
// A tick held high for several cycles therefore yields a single event.
module tick_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  output logic o_rise
);

  logic r_tick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= i_tick;
    end
  end

  assign o_rise = i_tick & ~r_tick_d;

endmodule

// File: rtl/tick_period_monitor.sv
// Measures the clk-cycle interval between successive tick pulses and checks it
// against NOM_PERIOD +/- TOL.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : low returns the monitor to IDLE on the next edge
//   tick_in     : tick pulse (rising edge is the event)
//   period      : last measured interval, held until the next measurement
//   period_vld  : 1-cycle strobe, period updated
//   early       : 1-cycle strobe with period_vld, interval below NOM_PERIOD-TOL
//   late        : 1-cycle strobe, no tick within NOM_PERIOD+TOL cycles
//   locked      : LOCK_CNT consecutive in-tolerance intervals seen
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int NOM_PERIOD = 25_000_000,
  parameter int TOL        = 1_000,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             early,
  output logic             late,
  output logic             locked
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  LO_BOUND = CNT_W'(lo_bound(NOM_PERIOD, TOL));
  localparam logic [CNT_W-1:0]  HI_BOUND = CNT_W'(hi_bound(NOM_PERIOD, TOL));
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  generate
    if (lo_bound(NOM_PERIOD, TOL) < 0) begin : g_bad_bounds
      $error("tick_period_monitor: NOM_PERIOD-TOL must not be negative");
    end
    if (CNT_W < min_cnt_w(NOM_PERIOD, TOL)) begin : g_bad_width
      $error("tick_period_monitor: CNT_W too small for NOM_PERIOD+TOL");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
      $error("tick_period_monitor: LOCK_CNT must be at least 1");
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [GOOD_W-1:0]  r_good;
  logic               w_event;
  logic               w_early;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [GOOD_W-1:0]  w_good_inc;

  tick_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (tick_in),
    .o_rise (w_event)
  );

  // The timeout at HI_BOUND normally stops the counter first; saturation only
  // guards against wrap if the counter is ever widened past that point.
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_good_inc = (r_good == GOOD_MAX) ? r_good : r_good + 1'b1;
  // Intervals above HI_BOUND cannot reach the compare: they time out instead.
  assign w_early    = (r_cnt < LO_BOUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_good     <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      early      <= 1'b0;
      late       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      early      <= 1'b0;
      late       <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_good  <= '0;
        locked  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // First event only starts timing; there is no interval to report yet.
            if (w_event) begin
              r_cnt   <= CNT_W'(1);
              r_state <= ST_MEAS;
            end else begin
              r_cnt <= '0;
            end
          end
          ST_MEAS: begin
            // An event coinciding with cnt==HI_BOUND is a good interval, not a timeout.
            if (w_event) begin
              r_cnt      <= CNT_W'(1);
              period     <= r_cnt;
              period_vld <= 1'b1;
              if (w_early) begin
                early  <= 1'b1;
                r_good <= '0;
                locked <= 1'b0;
              end else begin
                r_good <= w_good_inc;
                locked <= (w_good_inc == GOOD_MAX);
              end
            end else if (r_cnt == HI_BOUND) begin
              late    <= 1'b1;
              locked  <= 1'b0;
              r_good  <= '0;
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
module tb_tick_period_monitor;

  localparam int NOM   = 20;
  localparam int TOL   = 2;
  localparam int LOCKN = 3;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         tick_in = 1'b0;
  logic [W-1:0] period;
  logic         period_vld, early, late, locked;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic         vld;
    logic         early;
    logic         late;
    logic [W-1:0] period;
    logic         locked;
  } obs_t;

  obs_t exp_q[$];

  tick_period_monitor #(
    .NOM_PERIOD (NOM),
    .TOL        (TOL),
    .LOCK_CNT   (LOCKN),
    .CNT_W      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick_in    (tick_in),
    .period     (period),
    .period_vld (period_vld),
    .early      (early),
    .late       (late),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    obs_t act;
    obs_t exp;
    if (rst_n && (period_vld || early || late)) begin
      act = '{vld: period_vld, early: early, late: late,
              period: (period_vld ? period : '0), locked: locked};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected: got vld=%0b early=%0b late=%0b period=%0d locked=%0b, required none",
                 act.vld, act.early, act.late, act.period, act.locked);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL strobe: got vld=%0b early=%0b late=%0b period=%0d locked=%0b, required vld=%0b early=%0b late=%0b period=%0d locked=%0b",
                   act.vld, act.early, act.late, act.period, act.locked,
                   exp.vld, exp.early, exp.late, exp.period, exp.locked);
        end else begin
          $display("strobe ok: vld=%0b early=%0b late=%0b period=%0d locked=%0b",
                   act.vld, act.early, act.late, act.period, act.locked);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check ok %s: %0d", name, act);
    end
  endtask

  // Issue one tick now (held 'width' cycles) and keep the line idle so the
  // next tick comes 'gap' cycles later. kind: 0 no report, 1 good, 2 early.
  // 'per'/'lk' describe the report for the interval ending at this tick;
  // late_after expects a timeout during this gap.
  task automatic row(input int gap, input int width, input int kind,
                     input int per, input bit lk, input bit late_after);
    if (kind != 0)
      exp_q.push_back('{vld: 1'b1, early: (kind == 2), late: 1'b0,
                        period: W'(per), locked: lk});
    if (late_after)
      exp_q.push_back('{vld: 1'b0, early: 1'b0, late: 1'b1,
                        period: '0, locked: 1'b0});
    $display("tick: gap=%0d width=%0d kind=%0d period=%0d locked=%0b late_after=%0b",
             gap, width, kind, per, lk, late_after);
    tick_in = 1'b1;
    repeat (width) @(posedge clk);
    #1 tick_in = 1'b0;
    repeat (gap - width) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("reset_period", int'(period), 0);
    check("reset_vld", int'(period_vld), 0);
    check("reset_early", int'(early), 0);
    check("reset_late", int'(late), 0);
    check("reset_locked", int'(locked), 0);
    @(posedge clk); #1;

    // 2. nominal train
    row(20, 1, 0,  0, 1'b0, 1'b0);
    row(20, 1, 1, 20, 1'b0, 1'b0);
    row(20, 1, 1, 20, 1'b0, 1'b0);
    row(20, 1, 1, 20, 1'b1, 1'b0);
    row(15, 1, 1, 20, 1'b1, 1'b0);
    // 3. early tick, relock
    row(20, 1, 2, 15, 1'b0, 1'b0);
    row(20, 1, 1, 20, 1'b0, 1'b0);
    row(20, 1, 1, 20, 1'b0, 1'b0);
    // 4. locked, then missing tick -> timeout
    row(30, 1, 1, 20, 1'b1, 1'b1);
    row(20, 1, 0,  0, 1'b0, 1'b0);
    // 5. boundaries 18, 22, 17
    row(18, 1, 1, 20, 1'b0, 1'b0);
    row(22, 1, 1, 18, 1'b0, 1'b0);
    row(17, 1, 1, 22, 1'b1, 1'b0);
    row(20, 1, 2, 17, 1'b0, 1'b0);
    // 6. wide ticks count once
    row(20, 4, 1, 20, 1'b0, 1'b0);
    row(20, 4, 1, 20, 1'b0, 1'b0);
    row(20, 4, 1, 20, 1'b1, 1'b0);
    check("locked_before_en_low", int'(locked), 1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("en_low_locked", int'(locked), 0);
    check("en_low_period_held", int'(period), 20);
    @(posedge clk); #1 en = 1'b1;
    row(20, 1, 0,  0, 1'b0, 1'b0);
    row(10, 1, 1, 20, 1'b0, 1'b0);
    // reset mid-interval, 10 cycles after the last tick
    rst_n = 1'b0;
    #2;
    check("async_rst_period", int'(period), 0);
    check("async_rst_locked", int'(locked), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    row(20, 1, 0,  0, 1'b0, 1'b0);
    row(30, 1, 1, 20, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    check("pending_expectations", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
